// File: rtl/upstream_link_tx_pkg.sv
// Shared constants, state type and byte-lane mapping for the upstream link transmitter.
package upstream_link_pkg;

  localparam int CORE_WIDTH       = 64;
  localparam int NUM_CH           = 2;
  localparam int CH_WIDTH         = 8;
  localparam int BEATS_PER_WORD   = 4;
  localparam int BEATS_PER_ENTRY  = 2;
  localparam int CREDITS_PER_WORD = BEATS_PER_WORD / BEATS_PER_ENTRY;
  localparam int DEF_CREDITS      = 8;
  localparam int BEAT_W           = $clog2(BEATS_PER_WORD);

  typedef logic [BEAT_W-1:0] beat_t;

  localparam beat_t LAST_BEAT = beat_t'(BEATS_PER_WORD - 1);

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  // Returns {ch1, ch0} for a given beat. Channel 0 takes bytes 0,1,4,5 and
  // channel 1 takes 2,3,6,7, so the receiver can rebuild 16-bit halves per channel.
  function automatic logic [NUM_CH*CH_WIDTH-1:0] beat_bytes(
    input logic [CORE_WIDTH-1:0] word,
    input beat_t                 beat
  );
    logic [2:0] idx0;
    logic [2:0] idx1;
    idx0 = {beat[1], 1'b0, beat[0]};
    idx1 = idx0 + 3'd2;
    return {word[CH_WIDTH*idx1 +: CH_WIDTH], word[CH_WIDTH*idx0 +: CH_WIDTH]};
  endfunction

endpackage

// File: rtl/upstream_link_tx_if.sv
// Core handshake, credit token and I/O channel signals of the upstream link.
interface upstream_link_tx_if;

  logic                                    core_valid_in;
  logic [upstream_link_pkg::CORE_WIDTH-1:0] core_data_in;
  logic                                    core_ready_out;
  logic                                    io_token;
  logic                                    io_valid_out;
  logic [upstream_link_pkg::CH_WIDTH-1:0]  io_data_out_ch0;
  logic [upstream_link_pkg::CH_WIDTH-1:0]  io_data_out_ch1;
  logic                                    credit_err;

  // Environment side: core producer plus the downstream token return.
  modport master (
    output core_valid_in, core_data_in, io_token,
    input  core_ready_out, io_valid_out, io_data_out_ch0, io_data_out_ch1, credit_err
  );

  // Transmitter side.
  modport slave (
    input  core_valid_in, core_data_in, io_token,
    output core_ready_out, io_valid_out, io_data_out_ch0, io_data_out_ch1, credit_err
  );

endinterface

// File: rtl/upstream_link_tx_credit_counter.sv
// Link credit tracker: toggle-token edge detect, per-word debit, saturating
// return and a sticky overflow flag. Usable on either end of the link.
module link_credit_counter
  import upstream_link_pkg::*;
#(
  parameter int CREDITS = DEF_CREDITS,
  localparam int CW     = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          debit_i,
  input  logic          token_i,
  output logic [CW-1:0] credits_o,
  output logic          credit_err_o
);

  localparam logic [CW:0] DEBIT   = (CW+1)'(CREDITS_PER_WORD);
  localparam logic [CW:0] CRD_MAX = (CW+1)'(CREDITS);

  logic          token_q;
  logic [CW-1:0] credits_q, credits_d;
  logic          err_q, err_d;
  logic          tok_edge;
  logic [CW:0]   sum;

  // Net credit change for this cycle; a return beyond the pool size saturates and flags.
  always_comb begin
    tok_edge  = token_i ^ token_q;
    sum       = {1'b0, credits_q} + {{CW{1'b0}}, tok_edge} - (debit_i ? DEBIT : '0);
    credits_d = sum[CW-1:0];
    err_d     = err_q;
    if (sum > CRD_MAX) begin
      credits_d = CRD_MAX[CW-1:0];
      err_d     = 1'b1;
    end
  end

  // Credit, token-history and error registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      token_q   <= 1'b0;
      credits_q <= CRD_MAX[CW-1:0];
      err_q     <= 1'b0;
    end else begin
      token_q   <= token_i;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign credits_o    = credits_q;
  assign credit_err_o = err_q;

endmodule

// File: rtl/upstream_link_tx.sv
// Upstream link transmitter: takes 64-bit core words and sends each as four
// beats over two 8-bit channels, gated by downstream buffer credits.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   TX_IDLE | no word in flight, outputs idle (valid 0, data 0x00)
//   TX_SEND | beat_q of the held word is on the channels this cycle
module upstream_link_tx
  import upstream_link_pkg::*;
#(
  parameter int CREDITS = DEF_CREDITS
) (
  input  logic               clk,
  input  logic               rst,
  upstream_link_tx_if.slave  bus
);

  localparam int CW = $clog2(CREDITS + 1);

  tx_state_e               state_q, state_d;
  beat_t                   beat_q, beat_d;
  logic [CORE_WIDTH-1:0]   hold_q, hold_d;
  logic                    io_valid_q, io_valid_d;
  logic [CH_WIDTH-1:0]     ch0_q, ch0_d;
  logic [CH_WIDTH-1:0]     ch1_q, ch1_d;
  logic [CW-1:0]           credits;
  logic                    word_slot;
  logic                    ready;
  logic                    accept;

  link_credit_counter #(.CREDITS(CREDITS)) u_credit (
    .clk          (clk),
    .rst          (rst),
    .debit_i      (accept),
    .token_i      (bus.io_token),
    .credits_o    (credits),
    .credit_err_o (bus.credit_err)
  );

  // Ready when the channels are free next cycle and a whole word's entries are available.
  always_comb begin
    word_slot = (state_q == TX_IDLE) || (beat_q == LAST_BEAT);
    ready     = rst && word_slot && (credits >= CW'(CREDITS_PER_WORD));
    accept    = ready && bus.core_valid_in;
  end

  // Next state, beat and hold word; output flops load the beat shown next cycle.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    hold_d  = hold_q;
    case (state_q)
      TX_IDLE: begin
        if (accept) begin
          state_d = TX_SEND;
          beat_d  = '0;
          hold_d  = bus.core_data_in;
        end
      end
      TX_SEND: begin
        if (beat_q != LAST_BEAT) begin
          beat_d = beat_q + beat_t'(1);
        end else if (accept) begin
          beat_d = '0;
          hold_d = bus.core_data_in;
        end else begin
          state_d = TX_IDLE;
          beat_d  = '0;
        end
      end
      default: begin
        state_d = TX_IDLE;
        beat_d  = '0;
      end
    endcase
    io_valid_d   = (state_d == TX_SEND);
    {ch1_d, ch0_d} = io_valid_d ? beat_bytes(hold_d, beat_d) : '0;
  end

  // State, hold and output registers; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= TX_IDLE;
      beat_q     <= '0;
      hold_q     <= '0;
      io_valid_q <= 1'b0;
      ch0_q      <= '0;
      ch1_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      hold_q     <= hold_d;
      io_valid_q <= io_valid_d;
      ch0_q      <= ch0_d;
      ch1_q      <= ch1_d;
    end
  end

  assign bus.core_ready_out  = ready;
  assign bus.io_valid_out    = io_valid_q;
  assign bus.io_data_out_ch0 = ch0_q;
  assign bus.io_data_out_ch1 = ch1_q;

endmodule

// File: tb/tb_upstream_link_tx.sv
// Bench for upstream_link_tx: directed scenarios followed by random traffic,
// all compared each cycle against a word/beat-queue model of the link.
module tb_upstream_link_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;

  upstream_link_tx_if bus ();

  upstream_link_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  int          m_credits = 8;
  bit          m_err     = 1'b0;
  bit          m_tok     = 1'b0;
  bit          m_valid   = 1'b0;
  logic [7:0]  m_c0      = 8'h00;
  logic [7:0]  m_c1      = 8'h00;
  logic [15:0] m_beats[$];
  bit          last_acc  = 1'b0;
  int          ch0_idx[4] = '{0, 1, 4, 5};
  int          ch1_idx[4] = '{2, 3, 6, 7};

  bit          tok_lvl = 1'b0;
  logic [63:0] word;

  task automatic step(input bit v, input logic [63:0] d, input bit tok, input bit r);
    bit exp_ready;
    bit tok_edge;
    @(negedge clk);
    bus.core_valid_in = v;
    bus.core_data_in  = d;
    bus.io_token      = tok;
    rst               = r;
    #1;
    exp_ready = r && (m_beats.size() == 0) && (m_credits >= 2);
    checks++;
    assert (bus.core_ready_out === exp_ready) else begin
      errors++;
      $error("FAIL ready observed %0b expected %0b", bus.core_ready_out, exp_ready);
    end
    checks++;
    assert (bus.io_valid_out === m_valid) else begin
      errors++;
      $error("FAIL io_valid observed %0b expected %0b", bus.io_valid_out, m_valid);
    end
    checks++;
    assert (bus.io_data_out_ch0 === m_c0) else begin
      errors++;
      $error("FAIL ch0 observed %02h expected %02h", bus.io_data_out_ch0, m_c0);
    end
    checks++;
    assert (bus.io_data_out_ch1 === m_c1) else begin
      errors++;
      $error("FAIL ch1 observed %02h expected %02h", bus.io_data_out_ch1, m_c1);
    end
    checks++;
    assert (bus.credit_err === m_err) else begin
      errors++;
      $error("FAIL credit_err observed %0b expected %0b", bus.credit_err, m_err);
    end
    @(posedge clk);
    last_acc = v && exp_ready;
    if (!r) begin
      m_credits = 8;
      m_err     = 1'b0;
      m_tok     = 1'b0;
      m_beats.delete();
      m_valid   = 1'b0;
      m_c0      = 8'h00;
      m_c1      = 8'h00;
    end else begin
      tok_edge = (tok != m_tok);
      m_tok    = tok;
      m_credits = m_credits + (tok_edge ? 1 : 0) - (last_acc ? 2 : 0);
      if (m_credits > 8) begin
        m_credits = 8;
        m_err     = 1'b1;
      end
      if (last_acc)
        for (int k = 0; k < 4; k++)
          m_beats.push_back({d[8*ch1_idx[k] +: 8], d[8*ch0_idx[k] +: 8]});
      if (m_beats.size() > 0) begin
        {m_c1, m_c0} = m_beats.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
        m_c0    = 8'h00;
        m_c1    = 8'h00;
      end
    end
  endtask

  function automatic logic [63:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  initial begin
    bus.core_valid_in = 1'b0;
    bus.core_data_in  = '0;
    bus.io_token      = 1'b0;
    rst               = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held: ready and outputs low
    repeat (2) step(1'b0, '0, 1'b0, 1'b0);

    // Single word
    step(1'b1, 64'h0706050403020100, tok_lvl, 1'b1);
    repeat (6) step(1'b0, '0, tok_lvl, 1'b1);

    // Back-to-back until credits run out; a pending word then waits
    word = rand_word();
    repeat (24) begin
      step(1'b1, word, tok_lvl, 1'b1);
      if (last_acc) word = rand_word();
    end

    // Credit return: two edges on consecutive cycles release the waiting word
    repeat (2) begin
      tok_lvl = ~tok_lvl;
      step(1'b1, word, tok_lvl, 1'b1);
      if (last_acc) word = rand_word();
    end
    repeat (2) begin
      step(1'b1, word, tok_lvl, 1'b1);
      if (last_acc) word = rand_word();
    end
    repeat (5) step(1'b0, '0, tok_lvl, 1'b1);

    // Simultaneous accept and token edge at two credits
    repeat (2) begin
      tok_lvl = ~tok_lvl;
      step(1'b0, '0, tok_lvl, 1'b1);
    end
    tok_lvl = ~tok_lvl;
    word = rand_word();
    step(1'b1, word, tok_lvl, 1'b1);
    word = rand_word();
    repeat (6) step(1'b1, word, tok_lvl, 1'b1);

    // Overflow: return more credits than the pool holds
    repeat (8) begin
      tok_lvl = ~tok_lvl;
      step(1'b0, '0, tok_lvl, 1'b1);
    end
    repeat (3) step(1'b0, '0, tok_lvl, 1'b1);

    // Reset mid-word during beat 1
    tok_lvl = 1'b0;
    step(1'b0, '0, tok_lvl, 1'b0);
    step(1'b1, rand_word(), tok_lvl, 1'b1);
    step(1'b0, '0, tok_lvl, 1'b1);
    step(1'b0, '0, tok_lvl, 1'b0);
    repeat (4) step(1'b0, '0, tok_lvl, 1'b1);

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      bit v;
      bit r;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 99) != 0);
      if (!r) tok_lvl = 1'b0;
      else if ($urandom_range(0, 9) < 4) tok_lvl = ~tok_lvl;
      step(v, rand_word(), tok_lvl, r);
      if (!r) tok_lvl = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/upstream_link_tx.md
# upstream_link_tx

Transmit end of the two-channel off-chip link. Accepts 64-bit core words over a valid/ready handshake and serializes each word into four beats on two 8-bit I/O channels. Spends link credits for the downstream per-channel buffers and recovers them from a toggle-encoded token returned by the downstream end. Sits between the core and the pads, opposite the downstream channel receivers and their 8-entry × 16-bit buffer memories.

## Interface
- `CORE_WIDTH`, default 64: core word width; fixed at 64.
- `CH_WIDTH`, default 8: bits per I/O channel per beat.
- `CREDITS`, default 8: downstream buffer entries per channel. One entry is 16 bits, i.e. 2 beats.

- `clk` in 1: single clock for the core and I/O sides.
- `rst` in 1: synchronous, active-low. `rst==0` at a posedge resets the block.
- `core_valid_in` in 1: core word valid.
- `core_data_in` in 64: core word.
- `core_ready_out` out 1: block accepts a word at this edge if `core_valid_in` is high.
- `io_token` in 1: credit return. Each level transition returns one entry credit.
- `io_valid_out` out 1: beat valid on both channels.
- `io_data_out_ch0` out 8: channel 0 beat.
- `io_data_out_ch1` out 8: channel 1 beat.
- `credit_err` out 1: sticky flag for credit overflow; cleared only by reset.

## Operation
- **Byte mapping.** Bytes are B0 = `data[7:0]` … B7 = `data[63:56]`.
  - Channel 0 carries B0, B1, B4, B5.
  - Channel 1 carries B2, B3, B6, B7.
  - Beat k drives (ch0, ch1) = (B0, B2), (B1, B3), (B4, B6), (B5, B7) for k = 0..3.
  - This matches the downstream reassembly: ch0 = `{data[47:32], data[15:0]}`, ch1 = `{data[63:48], data[31:16]}`.
- **FSM.**
  - States: IDLE and SEND. SEND uses a 2-bit beat counter `beat`.
  - IDLE → SEND on accept, with `beat` = 0.
  - In SEND, `beat` increments every cycle. No I/O backpressure exists; the credits guarantee buffer space downstream.
  - At `beat==3`: a new accept keeps the FSM in SEND with `beat` = 0; otherwise it returns to IDLE.
- **Ready.**
  - `core_ready_out` = (IDLE or (SEND and `beat==3`)) and `credits >= 2`.
  - Ready is combinational from registered state.
  - An accept latches `core_data_in` into the shift/hold register.
- **Credits.**
  - `credits` is a counter, width `$clog2(CREDITS+1)`. It resets to `CREDITS`.
  - An accept debits 2, one entry per channel pair per half-word. Both channels consume entries in lockstep, so one counter covers both.
  - A token edge is `io_token ^ token_q`, where `token_q` is a register reset to 0. The peer must also reset its token to 0. The link returns at most one credit per cycle.
  - Accept and edge in the same cycle give a net change of −1.
  - An edge while `credits==CREDITS` (or one that would exceed `CREDITS`) leaves the counter saturated at `CREDITS` and sets `credit_err`.
- **Reset.** Reset mid-word drops the word. The FSM goes to IDLE, `credits` to `CREDITS`, and `token_q` to 0. No partial beats appear after reset.

## Timing
- **Reset values:** `core_ready_out` 0 while `rst==0`; `io_valid_out` 0; `io_data_out_ch*` 0x00; `credit_err` 0.
- **First ready:** `core_ready_out` = 1 in the first cycle after reset release, since credits = 8.
- **Latency:** accept at edge t → beat 0 registered and visible in cycle t+1. Beats 1–3 follow in t+2..t+4 with `io_valid_out` = 1.
- **Throughput:** back-to-back words give continuous `io_valid_out`, at 1 word per 4 cycles.
- **Outputs:** all I/O outputs come straight from flops. Idle outputs hold `io_valid_out` 0 and data 0x00.
- **Credit update:** a token edge sampled at edge t updates `credits` at edge t. The extra credit can enable ready in cycle t+1.
- **Credit stall:** with credits < 2, ready stays low. The FSM finishes the current word and idles until credits return.

## Structure
- **Package `upstream_link_pkg`:**
  - Constants `NUM_CH=2`, `CH_WIDTH`, `BEATS_PER_WORD=4`, `BEATS_PER_ENTRY=2`, `CREDITS_PER_WORD=2`.
  - State enum `{TX_IDLE, TX_SEND}`.
  - The function mapping (word, beat) → channel bytes.
- **Sub-module `link_credit_counter`:** token edge detect, saturating add, debit, and `credit_err`. The downstream side can reuse it for checking.
- **Top:** FSM, hold register, output flops.

## Test plan
- **Single word:** reset, release, send `0x0706050403020100`. Expect ch0 = 00, 01, 04, 05 and ch1 = 02, 03, 06, 07 in cycles t+1..t+4, `io_valid_out` high for exactly 4 cycles, credits 8 → 6.
- **Back-to-back:** valid held for 4 words with no token. Expect 4 words accepted at 4-cycle spacing and `io_valid_out` continuous for 16 cycles. Credits reach 0 and ready drops; a 5th word is not accepted.
- **Credit return:** from credits = 0, toggle `io_token` twice on consecutive cycles. Expect ready to rise in the cycle after the second edge, the 5th word to be sent, and credits to return to 0.
- **Simultaneous:** a token edge in the same cycle as an accept at credits = 2. Expect credits = 1 and ready low afterward.
- **Overflow:** a token edge at credits = 8. Expect credits to stay 8 and `credit_err` = 1 until the next reset.
- **Reset mid-word:** assert `rst`=0 during beat 1. Expect `io_valid_out` 0 at the next edge, no remaining beats, credits = 8, and ready = 1 after release.
